seq_event_counter: RTL

Downstream consumer of the serial sequence detector's 2-bit class code (00 = "101", 01 = "1011", 10 = "111 or more", 11 = none/other). It converts code changes into one-shot class events and counts each class in a saturating counter. It also flags saturation and gives a request/acknowledge read port to a host or display stage. It shares clk with the detector; the code input is synchronous to clk.

---
 rtl/seq_detect_pkg.sv | 34 +++
 rtl/sat_counter.sv | 40 ++++
 rtl/seq_event_counter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial sequence detector and its event counter.
// Holds the 2-bit class codes, read-select codes and a class decode helper.
package seq_detect_pkg;

    // Class codes produced by the sequence detector
    localparam logic [1:0] CODE_101   = 2'b00;
    localparam logic [1:0] CODE_1011  = 2'b01;
    localparam logic [1:0] CODE_1MORE = 2'b10;
    localparam logic [1:0] CODE_NONE  = 2'b11;

    // Read-select codes for the counter read port
    localparam logic [1:0] SEL_101    = 2'd0;
    localparam logic [1:0] SEL_1011   = 2'd1;
    localparam logic [1:0] SEL_1MORE  = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    // Number of counted classes and width of each LED stretch counter
    localparam int N_CLASS   = 3;
    localparam int STRETCH_W = 8;

    // One-hot class decode: bit0 = 101, bit1 = 1011, bit2 = 1more
    function automatic logic [N_CLASS-1:0] class_onehot(input logic [1:0] code);
        logic [N_CLASS-1:0] onehot;
        onehot = '0;
        case (code)
            CODE_101:   onehot = 3'b001;
            CODE_1011:  onehot = 3'b010;
            CODE_1MORE: onehot = 3'b100;
            default:    onehot = 3'b000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Unsigned saturating event counter with a sticky saturation flag.
// Synchronous clear has priority over an increment in the same cycle.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    // Count events, hold at the maximum and remember that it was hit
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (inc) begin
            if (r_cnt == CNT_MAX) begin
                r_sat <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign cnt = r_cnt;
    assign sat = r_sat;

endmodule

// File: rtl/seq_event_counter.sv
// Converts sequence-detector class-code changes into one-shot events, counts
// each class in a saturating counter and serves the counts over a
// request/acknowledge read port.
// Optional build macro EVT_STRETCH_EN: stretches each evt_pulse bit to
// STRETCH_LEN cycles (retriggerable) for driving board LEDs.
module seq_event_counter
    import seq_detect_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int STRETCH_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         code,
    input  logic               clr,
    input  logic               rd_req,
    input  logic [1:0]         rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_ack,
    output logic [N_CLASS-1:0] evt_pulse
);

    // Elaboration-time parameter range checks
    if (CNT_W < 3 || CNT_W > 32) begin : g_bad_cnt_w
        $error("seq_event_counter: CNT_W must be in 3..32");
    end
    if (STRETCH_LEN < 1 || STRETCH_LEN > 255) begin : g_bad_stretch_len
        $error("seq_event_counter: STRETCH_LEN must be in 1..255");
    end

    logic [1:0]         r_code_q;
    logic [1:0]         r_code_prev;
    logic               w_evt;
    logic [N_CLASS-1:0] w_evt_vec;
    logic [N_CLASS-1:0] w_evt_kept;
    logic [CNT_W-1:0]   w_cnt [N_CLASS];
    logic [N_CLASS-1:0] w_sat;
    logic [CNT_W-1:0]   w_rd_mux;
    logic [CNT_W-1:0]   r_rd_data;
    logic               r_rd_ack;

    // Register the incoming code and keep the previous one for change detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code_q    <= CODE_NONE;
            r_code_prev <= CODE_NONE;
        end else begin
            r_code_q    <= code;
            r_code_prev <= r_code_q;
        end
    end

    // An event is a change into any real class; holding a code gives no repeats
    assign w_evt      = (r_code_q != r_code_prev) && (r_code_q != CODE_NONE);
    assign w_evt_vec  = w_evt ? class_onehot(r_code_q) : '0;
    // Events swallowed by a same-cycle clear must not show on evt_pulse
    assign w_evt_kept = w_evt_vec & {N_CLASS{~clr}};

    for (genvar i = 0; i < N_CLASS; i++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_sat_counter (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .inc (w_evt_vec[i]),
            .cnt (w_cnt[i]),
            .sat (w_sat[i])
        );
    end

    // Select the counter or status word to return on a read
    // NOTE: give every combinational output a default first so no path infers a latch.
    always_comb begin
        w_rd_mux = '0;
        case (rd_sel)
            SEL_101:    w_rd_mux = w_cnt[0];
            SEL_1011:   w_rd_mux = w_cnt[1];
            SEL_1MORE:  w_rd_mux = w_cnt[2];
            SEL_STATUS: w_rd_mux[N_CLASS-1:0] = w_sat;
            default:    w_rd_mux = '0;
        endcase
    end

    // Capture pre-update counter values on a request; ack follows one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_ack <= rd_req;
            if (rd_req) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign rd_ack  = r_rd_ack;
    assign rd_data = r_rd_data;

`ifdef EVT_STRETCH_EN
    localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH_LEN);

    logic [STRETCH_W-1:0] r_stretch [N_CLASS];

    // Per-class retriggerable down-counters that hold each LED on after an event
    // NOTE: this small array is flops, not RAM, so resetting every entry is cheap and keeps LEDs dark after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CLASS; i++) begin
                r_stretch[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CLASS; i++) begin
                if (w_evt_kept[i]) begin
                    r_stretch[i] <= STRETCH_LOAD;
                end else if (r_stretch[i] != '0) begin
                    r_stretch[i] <= r_stretch[i] - 1'b1;
                end
            end
        end
    end

    // A class output is lit while its stretch counter is non-zero
    always_comb begin
        evt_pulse = '0;
        for (int i = 0; i < N_CLASS; i++) begin
            evt_pulse[i] = (r_stretch[i] != '0);
        end
    end
`else
    logic [N_CLASS-1:0] r_evt_pulse;

    // Single-cycle event pulse, aligned with the counter increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_evt_pulse <= '0;
        end else begin
            r_evt_pulse <= w_evt_kept;
        end
    end

    assign evt_pulse = r_evt_pulse;
`endif

endmodule
